// File: rtl/mem_bus_arbiter.sv
// Arbitrates the core's fetch (I) and data (D) requesters onto one memory port.
// D is preferred; a starvation counter forces one I grant after STARVE_LIMIT D grants.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_data_ok,
  output logic [31:0]           i_data,
  input  logic                  d_valid,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [2:0]            d_size,
  input  logic [DATA_W/8-1:0]   d_strobe,
  input  logic [DATA_W-1:0]     d_data,
  output logic                  d_data_ok,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req_valid,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [2:0]            mem_req_size,
  output logic [DATA_W/8-1:0]   mem_req_strobe,
  output logic [DATA_W-1:0]     mem_req_data,
  input  logic                  mem_resp_ok,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [STRB_W-1:0] strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              terr_q, terr_d;
  logic              grant_d, grant_i;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    starve_d = starve_q;
    tcnt_d   = tcnt_q;
    terr_d   = terr_q;
    grant_d  = d_valid && !(i_valid && (starve_q == STARVE_MAX));
    grant_i  = !grant_d && i_valid;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = BUSY_D;
          addr_d   = d_addr;
          size_d   = d_size;
          strobe_d = d_strobe;
          data_d   = d_data;
          tcnt_d   = '0;
          if (!i_valid) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d  = BUSY_I;
          addr_d   = i_addr;
          size_d   = 3'd2;
          strobe_d = '0;
          data_d   = '0;
          tcnt_d   = '0;
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp_ok) begin
          state_d = IDLE;
        end else begin
          // Counter saturates; the flag is sticky so the FSM simply keeps waiting.
          if (tcnt_q != TO_MAX) tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q >= TO_MAX - 1'b1) terr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      starve_q <= '0;
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      starve_q <= starve_d;
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
    end
  end

  // A requester that dropped valid before the response was flushed: no pulse.
  assign i_data_ok      = (state_q == BUSY_I) && mem_resp_ok && i_valid;
  assign d_data_ok      = (state_q == BUSY_D) && mem_resp_ok && d_valid;
  assign i_data         = i_data_ok ? (addr_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0]) : 32'h0;
  assign d_rdata        = d_data_ok ? mem_resp_data : '0;
  assign mem_req_valid  = (state_q != IDLE);
  assign mem_req_addr   = addr_q;
  assign mem_req_size   = size_q;
  assign mem_req_strobe = strobe_q;
  assign mem_req_data   = data_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: tasks push expected responses, a monitor
// pops them whenever a data_ok pulse appears.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 64, DATA_W = 64, STARVE_LIMIT = 4, TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_valid = 1'b0;
  logic [63:0]       i_addr = '0;
  logic              i_data_ok;
  logic [31:0]       i_data;
  logic              d_valid = 1'b0;
  logic [63:0]       d_addr = '0;
  logic [2:0]        d_size = '0;
  logic [7:0]        d_strobe = '0;
  logic [63:0]       d_data = '0;
  logic              d_data_ok;
  logic [63:0]       d_rdata;
  logic              mem_req_valid;
  logic [63:0]       mem_req_addr;
  logic [2:0]        mem_req_size;
  logic [7:0]        mem_req_strobe;
  logic [63:0]       mem_req_data;
  logic              mem_resp_ok = 1'b0;
  logic [63:0]       mem_resp_data = '0;
  logic              timeout_err;

  typedef struct packed { logic is_d; logic [63:0] data; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_data(d_data),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size),
    .mem_req_strobe(mem_req_strobe), .mem_req_data(mem_req_data),
    .mem_resp_ok(mem_resp_ok), .mem_resp_data(mem_resp_data), .timeout_err(timeout_err)
  );

  // Response monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    checks++;
    if ((!i_data_ok && i_data !== 32'h0) || (!d_data_ok && d_rdata !== 64'h0)) begin
      failures++;
      $display("[TB] FAIL idle_data_zero i_data=%h d_rdata=%h required 0", i_data, d_rdata);
    end
    if (i_data_ok || d_data_ok) begin
      checks++;
      if (i_data_ok && d_data_ok) begin
        failures++;
        $display("[TB] FAIL resp_overlap i_ok=1 d_ok=1 required one");
      end else if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_resp i_ok=%0b d_ok=%0b required none", i_data_ok, d_data_ok);
      end else begin
        mon_e = sb_q.pop_front();
        if (d_data_ok !== mon_e.is_d ||
            (mon_e.is_d ? d_rdata : {32'h0, i_data}) !== mon_e.data) begin
          failures++;
          $display("[TB] FAIL resp_match got is_d=%0b data=%h required is_d=%0b data=%h",
                   d_data_ok, mon_e.is_d ? d_rdata : {32'h0, i_data}, mon_e.is_d, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic expect_resp(input logic is_d, input logic [63:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req_valid !== 1'b1 && n < 50);
    if (mem_req_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL req_wait mem_req_valid=%b required 1 within 50 cycles", mem_req_valid);
    end
  endtask

  task automatic pulse_resp(input int gap, input logic [63:0] data);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    mem_resp_ok = 1'b1;
    mem_resp_data = data;
    @(posedge clk); #1;
    mem_resp_ok = 1'b0;
    mem_resp_data = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_size, mem_req_strobe, mem_req_data, timeout_err} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got v=%b a=%h s=%h st=%h d=%h err=%b required all 0",
               mem_req_valid, mem_req_addr, mem_req_size, mem_req_strobe, mem_req_data, timeout_err);
    end
    // Stray response while idle must be ignored.
    @(posedge clk); #1 mem_resp_ok = 1'b1; mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    checks++;
    if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_resp_ignored i_ok=%b d_ok=%b v=%b required 0", i_data_ok, d_data_ok, mem_req_valid);
    end
    @(posedge clk); #1 mem_resp_ok = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_fetch();
    i_valid = 1'b1;
    i_addr  = 64'h8000_0004;
    expect_resp(1'b0, 64'h1111_1111);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fetch_latency_grant mem_req_valid=%b required 0", mem_req_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0004 || mem_req_size !== 3'd2 || mem_req_strobe !== 8'h00) begin
      failures++;
      $display("[TB] FAIL fetch_req got v=%b a=%h s=%0d st=%h required 1 80000004 2 00",
               mem_req_valid, mem_req_addr, mem_req_size, mem_req_strobe);
    end
    pulse_resp(1, 64'h1111_1111_2222_2222);
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fetch_release mem_req_valid=%b required 0", mem_req_valid);
    end
    i_valid = 1'b1;
    i_addr  = 64'h8000_0010;
    expect_resp(1'b0, 64'h4444_4444);
    wait_req();
    pulse_resp(0, 64'h3333_3333_4444_4444);
    i_valid = 1'b0;
  endtask

  task automatic test_both();
    i_valid = 1'b1; i_addr = 64'h8000_0000;
    d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd3; d_strobe = 8'hFF; d_data = 64'hDEAD_BEEF;
    expect_resp(1'b1, 64'hCAFE_F00D_1234_5678);
    expect_resp(1'b0, 64'hAAAA_BBBB);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_strobe !== 8'hFF || mem_req_addr !== 64'h8000_1000 ||
        mem_req_data !== 64'hDEAD_BEEF || mem_req_size !== 3'd3) begin
      failures++;
      $display("[TB] FAIL both_d_first got v=%b st=%h a=%h d=%h s=%0d required 1 ff 80001000 deadbeef 3",
               mem_req_valid, mem_req_strobe, mem_req_addr, mem_req_data, mem_req_size);
    end
    pulse_resp(0, 64'hCAFE_F00D_1234_5678);
    d_valid = 1'b0;
    wait_req();
    checks++;
    if (mem_req_strobe !== 8'h00 || mem_req_size !== 3'd2 || mem_req_addr !== 64'h8000_0000) begin
      failures++;
      $display("[TB] FAIL both_i_second got st=%h s=%0d a=%h required 00 2 80000000",
               mem_req_strobe, mem_req_size, mem_req_addr);
    end
    pulse_resp(0, 64'h9999_0000_AAAA_BBBB);
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL both_pulses pending=%0d required 0", sb_q.size());
    end
  endtask

  task automatic test_starve();
    logic ord [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] resp;
    i_addr = 64'h1000_0004;
    d_addr = 64'h2000_0008; d_size = 3'd3; d_strobe = 8'h0F; d_data = 64'h0123_4567_89AB_CDEF;
    i_valid = 1'b1;
    d_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_req();
      checks++;
      if (mem_req_addr !== (ord[k] ? 64'h2000_0008 : 64'h1000_0004)) begin
        failures++;
        $display("[TB] FAIL starve_order_%0d addr=%h required %h", k, mem_req_addr,
                 ord[k] ? 64'h2000_0008 : 64'h1000_0004);
      end
      resp = {32'(k + 16), 32'(k)};
      expect_resp(ord[k], ord[k] ? resp : {32'h0, resp[63:32]});
      pulse_resp(0, resp);
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
  endtask

  task automatic test_flush();
    i_valid = 1'b1; i_addr = 64'h3000_0000;
    wait_req();
    i_valid = 1'b0;
    @(posedge clk); #1 mem_resp_ok = 1'b1; mem_resp_data = 64'h7777_7777_8888_8888;
    @(negedge clk);
    checks++;
    if (i_data_ok !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_no_ok i_data_ok=%b required 0", i_data_ok);
    end
    @(posedge clk); #1 mem_resp_ok = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_idle mem_req_valid=%b required 0", mem_req_valid);
    end
    d_valid = 1'b1; d_addr = 64'h4000_0010; d_size = 3'd2; d_strobe = 8'h00;
    expect_resp(1'b1, 64'h0BAD_CAFE_5555_6666);
    wait_req();
    checks++;
    if (mem_req_addr !== 64'h4000_0010 || mem_req_strobe !== 8'h00) begin
      failures++;
      $display("[TB] FAIL flush_next_d a=%h st=%h required 40000010 00", mem_req_addr, mem_req_strobe);
    end
    pulse_resp(0, 64'h0BAD_CAFE_5555_6666);
    d_valid = 1'b0;
  endtask

  task automatic test_timeout();
    d_valid = 1'b1; d_addr = 64'h5000_0000; d_strobe = 8'h00;
    expect_resp(1'b1, 64'h1234_0000_0000_4321);
    wait_req();
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_early err=%b required 0", timeout_err);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_set err=%b required 1", timeout_err);
    end
    pulse_resp(0, 64'h1234_0000_0000_4321);
    d_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_sticky err=%b v=%b required 1 0", timeout_err, mem_req_valid);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_reset err=%b required 0", timeout_err);
    end
  endtask

  task automatic test_reset_busy();
    d_valid = 1'b1; d_addr = 64'h6000_0000; d_strobe = 8'hFF; d_data = 64'h5A5A;
    wait_req();
    reset = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    mem_resp_ok = 1'b1;
    mem_resp_data = 64'hDDDD_DDDD_DDDD_DDDD;
    @(negedge clk);
    checks++;
    if (d_data_ok !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0 ||
        mem_req_strobe !== 8'h00 || d_rdata !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_busy d_ok=%b v=%b a=%h st=%h rd=%h required all 0",
               d_data_ok, mem_req_valid, mem_req_addr, mem_req_strobe, d_rdata);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (d_data_ok !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_late_resp d_ok=%b v=%b required 0 0", d_data_ok, mem_req_valid);
    end
    @(posedge clk); #1 mem_resp_ok = 1'b0; mem_resp_data = '0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_both();
    test_starve();
    test_flush();
    test_timeout();
    test_reset_busy();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain pending=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
